// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor: D = A - B via nine's-complement add, one digit per cycle.
// Optional macro SIGN_MAG_EN: negative results are re-complemented to magnitude in a NEG pass.
module bcd_serial_subtractor #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  output logic [4*DIGITS-1:0]   D,
  output logic                  Bout,
  output logic                  busy,
  output logic                  done,
  output logic                  invalid
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

  typedef enum logic [2:0] {StIdle, StCheck, StSub, StNeg, StDone} state_e;

  state_e              state_q, state_d;
  logic [4*DIGITS-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                carry_q, carry_d;
  logic                bout_q, bout_d;
  logic                inv_q, inv_d;

  logic                bad_digit;
  logic [3:0]          op_a, op_b, res_digit;
  logic [4:0]          sum;
  logic                sum_carry;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (a_q[4*i +: 4] > 4'd9 || b_q[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // Shared add-and-correct datapath: op_a + (9 - op_b) + carry.
  always_comb begin
    op_a = a_q[{idx_q, 2'b00} +: 4];
    op_b = b_q[{idx_q, 2'b00} +: 4];
`ifdef SIGN_MAG_EN
    if (state_q == StNeg) begin
      op_a = 4'd0;
      op_b = d_q[{idx_q, 2'b00} +: 4];
    end
`endif
    sum = {1'b0, op_a} + {1'b0, 4'd9 - op_b} + {4'd0, carry_q};
    if (sum > 5'd9) begin
      res_digit = 4'(sum - 5'd10);
      sum_carry = 1'b1;
    end else begin
      res_digit = sum[3:0];
      sum_carry = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    bout_d  = bout_q;
    inv_d   = inv_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          idx_d   = '0;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (bad_digit) begin
          inv_d   = 1'b1;
          d_d     = '0;
          bout_d  = 1'b0;
          state_d = StDone;
        end else begin
          inv_d   = 1'b0;
          carry_d = 1'b1;
          idx_d   = '0;
          state_d = StSub;
        end
      end
      StSub: begin
        d_d[{idx_q, 2'b00} +: 4] = res_digit;
        carry_d = sum_carry;
        if (idx_q == LastIdx) begin
          bout_d  = ~sum_carry;
          idx_d   = '0;
          state_d = StDone;
`ifdef SIGN_MAG_EN
          if (!sum_carry) begin
            carry_d = 1'b1;
            state_d = StNeg;
          end
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
`ifdef SIGN_MAG_EN
      StNeg: begin
        d_d[{idx_q, 2'b00} +: 4] = res_digit;
        carry_d = sum_carry;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      bout_q  <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      bout_q  <= bout_d;
      inv_q   <= inv_d;
    end
  end

  assign D       = d_q;
  assign Bout    = bout_q;
  assign invalid = inv_q;
  assign busy    = (state_q == StCheck) || (state_q == StSub) || (state_q == StNeg);
  assign done    = (state_q == StDone);

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Self-checking bench for bcd_serial_subtractor (DIGITS=4): decimal-arithmetic model plus
// directed vectors with literal expectations.
module tb_bcd_serial_subtractor;

  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [15:0] d;
  logic        bout, busy, done, invalid;

  int checks = 0;
  int failures = 0;

  bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b),
    .D(d), .Bout(bout), .busy(busy), .done(done), .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decimal model: operands as integers, result re-encoded to BCD.
  function automatic void model(input logic [15:0] av, input logic [15:0] bv,
                                output logic [15:0] rd, output logic rb, output logic ri,
                                output int lat);
    int x, y, r;
    logic [3:0] dg;
    x = 0; y = 0; ri = 1'b0; rd = '0; rb = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      dg = av[4*i +: 4]; if (dg > 4'd9) ri = 1'b1; x = x * 10 + int'(dg);
      dg = bv[4*i +: 4]; if (dg > 4'd9) ri = 1'b1; y = y * 10 + int'(dg);
    end
    if (ri) begin
      lat = 2;
      return;
    end
    lat = DIGITS + 2;
    if (x >= y) r = x - y;
    else begin
      rb = 1'b1;
`ifdef SIGN_MAG_EN
      r = y - x;
      lat = 2 * DIGITS + 2;
`else
      r = (10 ** DIGITS) + x - y;
`endif
    end
    for (int i = 0; i < DIGITS; i++) begin
      rd[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
  endfunction

  // Transaction-level reference: phase counts cycles since the accepting edge.
  int          ph = 0;
  int          mlat = 0;
  logic [15:0] nd, exp_d = '0;
  logic        nb, ni, exp_bout = 1'b0, exp_inv = 1'b0;
  bit          mon_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      ph = 0; exp_d = '0; exp_bout = 1'b0; exp_inv = 1'b0;
      mon_en = 1'b1;
    end else if (ph == 0) begin
      if (start) begin
        model(a, b, nd, nb, ni, mlat);
        ph = 1;
      end
    end else if (ph == mlat) begin
      ph = 0;
    end else begin
      ph++;
      if (ph == mlat) begin
        exp_d = nd; exp_bout = nb; exp_inv = ni;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_busy", 32'(busy), 32'((ph >= 1) && (ph < mlat)));
      chk("mon_done", 32'(done), 32'((ph != 0) && (ph == mlat)));
      if (!((ph >= 1) && (ph < mlat))) begin
        chk("mon_d", 32'(d), 32'(exp_d));
        chk("mon_bout", 32'(bout), 32'(exp_bout));
        chk("mon_invalid", 32'(invalid), 32'(exp_inv));
      end
    end
  end

  task automatic wait_done(input string name, inout int n, input int elat);
    bit seen = 1'b0;
    while (!seen && n < 60) begin
      @(posedge clk); n++; #1;
      if (n == 1) start = 1'b0;
      if (done) seen = 1'b1;
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    chk({name, "_latency"}, 32'(n), 32'(elat));
  endtask

  task automatic run_op(input string name, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] ed, input logic eb, input logic ei, input int elat);
    int n = 0;
    a = av; b = bv; start = 1'b1;
    wait_done(name, n, elat);
    chk({name, "_d"}, 32'(d), 32'(ed));
    chk({name, "_bout"}, 32'(bout), 32'(eb));
    chk({name, "_invalid"}, 32'(invalid), 32'(ei));
    @(posedge clk); #1;
    chk({name, "_done_single"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [15:0] md;
    logic        mb, mi;
    int          ml, n;
    bit          stray;

    // Pin the model against hand-computed values.
    model(16'h5432, 16'h1234, md, mb, mi, ml);
    chk("model_5432_1234", {15'd0, mb, md}, {16'd0, 16'h4198});
    model(16'h0000, 16'h0001, md, mb, mi, ml);
`ifdef SIGN_MAG_EN
    chk("model_0_1", {15'd0, mb, md}, {15'd0, 1'b1, 16'h0001});
`else
    chk("model_0_1", {15'd0, mb, md}, {15'd0, 1'b1, 16'h9999});
`endif
    model(16'h00A0, 16'h0000, md, mb, mi, ml);
    chk("model_invalid", {mi, 31'(ml)}, {1'b1, 31'd2});

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_d", 32'(d), 32'd0);
    chk("reset_flags", {28'd0, bout, busy, done, invalid}, 32'd0);

    run_op("sub_pos", 16'h5432, 16'h1234, 16'h4198, 1'b0, 1'b0, 6);
`ifdef SIGN_MAG_EN
    run_op("sub_neg", 16'h1234, 16'h5432, 16'h4198, 1'b1, 1'b0, 10);
    run_op("zero_minus_one", 16'h0000, 16'h0001, 16'h0001, 1'b1, 1'b0, 10);
    run_op("zero_minus_max", 16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 10);
`else
    run_op("sub_neg", 16'h1234, 16'h5432, 16'h5802, 1'b1, 1'b0, 6);
    run_op("zero_minus_one", 16'h0000, 16'h0001, 16'h9999, 1'b1, 1'b0, 6);
    run_op("zero_minus_max", 16'h0000, 16'h9999, 16'h0001, 1'b1, 1'b0, 6);
`endif
    run_op("equal", 16'h7777, 16'h7777, 16'h0000, 1'b0, 1'b0, 6);
    run_op("invalid_a", 16'h00A0, 16'h0000, 16'h0000, 1'b0, 1'b1, 2);
    run_op("after_invalid", 16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, 6);
    run_op("invalid_b", 16'h0001, 16'hF000, 16'h0000, 1'b0, 1'b1, 2);

    // Second start while busy must be ignored.
    n = 0;
    a = 16'h5432; b = 16'h1234; start = 1'b1;
    @(posedge clk); n++; #1 start = 1'b0;
    @(posedge clk); n++; #1;
    @(posedge clk); n++; #1;
    a = 16'h9000; b = 16'h0000; start = 1'b1;
    @(posedge clk); n++; #1 start = 1'b0;
    wait_done("busy_start", n, 6);
    chk("busy_start_d", 32'(d), 32'h4198);
    chk("busy_start_bout", 32'(bout), 32'd0);
    @(posedge clk); #1;
    chk("busy_start_idle", 32'(busy), 32'd0);

    // Reset during SUB digit 2 aborts with no done pulse.
    a = 16'h1234; b = 16'h0000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("abort_d", 32'(d), 32'd0);
    chk("abort_flags", {28'd0, bout, busy, done, invalid}, 32'd0);
    stray = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) stray = 1'b1;
    end
    chk("abort_quiet", 32'(stray), 32'd0);
    run_op("after_abort", 16'h5432, 16'h1234, 16'h4198, 1'b0, 1'b0, 6);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bcd_serial_subtractor.md
BCD_SERIAL_SUBTRACTOR -- requirements
Module: bcd_serial_subtractor

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, which sets the number of BCD digits per operand (legal range 1..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction.
REQ-005 The block SHALL have port A, input, 4*DIGITS bits: minuend, packed BCD, least significant digit (LSD) in bits [3:0].
REQ-006 The block SHALL have port B, input, 4*DIGITS bits: subtrahend, packed BCD, same packing as A.
REQ-007 The block SHALL have port D, output, 4*DIGITS bits: registered packed-BCD result.
REQ-008 The block SHALL have port Bout, output, 1 bit: borrow, set when A < B.
REQ-009 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: single-cycle pulse marking result valid.
REQ-011 The block SHALL have port invalid, output, 1 bit: set when any operand digit is greater than 9.

Function
REQ-012 The block SHALL implement the FSM states IDLE, CHECK, SUB, NEG and DONE.
REQ-013 IDLE: start=1 SHALL capture A and B into internal registers, clear the digit index to 0, and move to CHECK; busy SHALL rise on that same edge.
REQ-014 CHECK: any captured digit greater than 9 SHALL set invalid=1, D=0 and Bout=0 and move to DONE; otherwise the block SHALL clear invalid, preset the carry to 1 and move to SUB.
REQ-015 SUB: the block SHALL process one digit per cycle, LSD first, as sum = A_i + (9 - B_i) + carry.
REQ-016 SUB digit correction: if sum > 9, the digit SHALL be sum - 10 and the carry 1; otherwise the digit SHALL be sum and the carry 0; the result digit SHALL be written into D[4i+3:4i].
REQ-017 SUB SHALL last exactly DIGITS cycles; after the final digit, Bout SHALL equal the inverse of the final carry.
REQ-018 When Bout=1, SUB SHALL be followed by NEG if SIGN_MAG_EN is defined; in all other cases SUB SHALL be followed by DONE.
REQ-019 NEG SHALL replace D with its 10's complement, one digit per cycle, LSD first, over DIGITS cycles, using the same add-and-correct datapath with operands 0 and D_i, then move to DONE.
REQ-020 DONE SHALL hold done=1 and busy=0 for exactly one cycle, then move to IDLE.
REQ-021 Latency from the start edge to the done cycle SHALL be DIGITS+2 cycles for a normal operation, 2*DIGITS+2 cycles with NEG, and 2 cycles for an invalid operation.
REQ-022 start SHALL be ignored whenever the state is not IDLE; A and B SHALL be sampled only on the accepting edge.
REQ-023 D, Bout and invalid SHALL hold their values from the done cycle until the next accepted start.
REQ-024 D SHALL not be valid for reading while busy=1.
REQ-025 rst=1 SHALL override start and all other inputs in every state.

Reset
REQ-026 On reset the block SHALL return to IDLE and set D=0, Bout=0, busy=0, done=0 and invalid=0.
REQ-027 On reset the block SHALL clear the internal carry, digit index and operand registers.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no done pulse.

Configuration
REQ-029 The block SHALL support the macro SIGN_MAG_EN.
REQ-030 With SIGN_MAG_EN defined, a negative result SHALL be output as its magnitude (|A-B|) with Bout=1.
REQ-031 Without SIGN_MAG_EN, a negative result SHALL be output as the 10's complement of |A-B| with Bout=1, the NEG state SHALL be unreachable, and no NEG logic SHALL be built.

Verification (DIGITS=4)
REQ-032 A=0x5432, B=0x1234, start -> at cycle 6: done=1, D=0x4198, Bout=0.
REQ-033 A=0x1234, B=0x5432 -> without SIGN_MAG_EN, at cycle 6: D=0x5802, Bout=1; with SIGN_MAG_EN, at cycle 10: D=0x4198, Bout=1.
REQ-034 A=0x0000, B=0x0001 -> without SIGN_MAG_EN: D=0x9999, Bout=1; with SIGN_MAG_EN: D=0x0001, Bout=1. Also A=B=0x7777 -> D=0x0000, Bout=0.
REQ-035 A=0x00A0, B=0x0000 -> at cycle 2: done=1, invalid=1, D=0x0000; a following valid start SHALL clear invalid.
REQ-036 A second start pulsed while busy, with different A -> ignored; the first result is unchanged.
REQ-037 rst asserted during SUB digit 2 -> next cycle: IDLE, all outputs 0, no done pulse; a new start then completes normally.
